fib_sequencer: RTL

FIB_SEQUENCER -- requirements
Module: fib_sequencer

---
 rtl/fib_pkg.sv | 27 ++
 rtl/fib_req_fifo.sv | 54 +++++
 rtl/fib_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and defaults for the fibonacci request sequencer
package fib_pkg;

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 1024;
  localparam int N_W             = 16;
  localparam int TAG_W           = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [N_W-1:0]   n;
  } fib_req_t;

  // Counter width able to hold limit-1; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/fib_req_fifo.sv
// rtl/fib_req_fifo.sv - in-order request queue, no bypass, push refused when full
module fib_req_fifo
  import fib_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  fib_req_t push_data,
  input  logic     pop,
  output fib_req_t pop_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = cnt_width(DEPTH);

  fib_req_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  // A full queue refuses a push even when a pop frees a slot in the same cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fib_sequencer.sv
// rtl/fib_sequencer.sv - queues fibonacci requests, drives one computation at a time, returns tagged results
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N_W-1:0]   req_n,
  input  logic [TAG_W-1:0] req_tag,
  output logic [N_W-1:0]   fib_din,
  output logic             fib_start,
  input  logic [N_W-1:0]   fib_dout,
  input  logic             fib_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N_W-1:0]   rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             err_sticky
);

  localparam int            CW    = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  state_t           state;
  logic [CW-1:0]    wait_cnt;
  logic [TAG_W-1:0] cur_tag;
  fib_req_t         head;
  fib_req_t         in_req;
  logic             full;
  logic             empty;
  logic             pop;

  assign req_ready = !full;
  assign in_req    = '{tag: req_tag, n: req_n};
  assign pop       = (state == IDLE) && !empty && !rsp_valid;

  fib_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_data (in_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fib_start  <= 1'b0;
      fib_din    <= '0;
      cur_tag    <= '0;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      fib_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            fib_din   <= head.n;
            cur_tag   <= head.tag;
            fib_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= GUARD;
        end
        // fib_done may still be high from the previous request here, so it is not looked at.
        GUARD: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (fib_done) begin
            rsp_data  <= fib_dout;
            rsp_err   <= 1'b0;
            rsp_tag   <= cur_tag;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wait_cnt == LIMIT) begin
            rsp_data   <= '0;
            rsp_err    <= 1'b1;
            rsp_tag    <= cur_tag;
            rsp_valid  <= 1'b1;
            err_sticky <= 1'b1;
            state      <= RESP;
          end else if (wait_cnt != {CW{1'b1}}) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
